// File: rtl/mm_pkg.sv
// mm_pkg: shared constants, FSM state encoding and lane-slicing helper for the
// mm MAC/accumulate datapath.
//   LANES      elements per feature/output word (weight tile is LANES x LANES)
//   DW         element width, two's-complement
//   AW         output-buffer address width
//   FRAC_BITS  fixed-point fraction bits removed from each product
//   CW         output-word counter width
package mm_pkg;
  localparam int LANES     = 16;
  localparam int DW        = 32;
  localparam int AW        = 11;
  localparam int FRAC_BITS = 0;
  localparam int CW        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Element idx of a packed LANES x DW word.
  function automatic logic [DW-1:0] lane_get(input logic [LANES*DW-1:0] vec, input int idx);
    return vec[idx*DW +: DW];
  endfunction
endpackage

// File: rtl/mm_mac_row.sv
// mm_mac_row: one output row of the mat-vec MAC.
//   Stage 1 registers N products (x[c]*w[c]) >>> FB truncated to W bits.
//   Stage 2 sums them with an adder tree and either accumulates or, on the
//   last chunk of a word, emits acc+sum on row_out and restarts the accumulator.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   load        capture products of the current chunk into stage 1
//   x, wrow     feature chunk and this row's weights, N x W each
//   s2_en       stage-1 contents are a live chunk to consume this cycle
//   s2_last     that chunk closes the output word
//   acc_clr     discard the accumulator (layer start / drain end); wins over s2_en
//   row_out     registered row result, updated only on a closing chunk
module mm_mac_row import mm_pkg::*; #(
  parameter int N  = LANES,
  parameter int W  = DW,
  parameter int FB = FRAC_BITS
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load,
  input  logic [N*W-1:0] x,
  input  logic [N*W-1:0] wrow,
  input  logic           s2_en,
  input  logic           s2_last,
  input  logic           acc_clr,
  output logic [W-1:0]   row_out
);
  logic [N*W-1:0] prods;
  logic [W-1:0]   tree [N];
  logic [W-1:0]   row_sum;
  logic [W-1:0]   acc_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mul
      logic signed [W-1:0]    xe, we;
      logic signed [W+FB-1:0] xs, ws, full;
      logic [W-1:0]           prod_reg;
      assign xe = x[gi*W +: W];
      assign we = wrow[gi*W +: W];
      // Only the low W+FB product bits survive the shift and truncation,
      // so a W+FB-bit multiply is exact for what we keep.
      assign xs   = (W+FB)'(xe);
      assign ws   = (W+FB)'(we);
      assign full = xs * ws;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     prod_reg <= '0;
        else if (load) prod_reg <= full[W+FB-1:FB];
      end
      assign prods[gi*W +: W] = prod_reg;
    end
  endgenerate

  // In-place pairwise reduction: after the pass with stride s, tree[i]
  // (i a multiple of 2s) holds the sum of 2s leaves. N is a power of two.
  always_comb begin
    for (int i = 0; i < N; i++) tree[i] = prods[i*W +: W];
    for (int s = 1; s < N; s = s * 2)
      for (int i = 0; i + s < N; i = i + 2 * s)
        tree[i] = tree[i] + tree[i+s];
  end
  assign row_sum = tree[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg <= '0;
      row_out <= '0;
    end else begin
      if (acc_clr)
        acc_reg <= '0;
      else if (s2_en)
        acc_reg <= s2_last ? '0 : acc_reg + row_sum;
      if (s2_en && s2_last)
        row_out <= acc_reg + row_sum;
    end
  end
endmodule

// File: rtl/mm_mac_acc.sv
// mm_mac_acc: 16x16 mat-vec MAC with accumulation across Ci chunks.
//   Accepts a feature chunk and weight tile per cycle in RUN, computes the
//   product in two register stages (mm_mac_row per output row) and emits the
//   accumulated word with its output-buffer address on the closing chunk.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, done          layer start / sequencer finished (1-cycle pulses)
//   in_valid, in_data    feature chunk
//   w_valid, w_data      weight tile, W[r][c] at (r*LANES+c)*DW
//   in_last, in_addr     closing-chunk flag and output address
//   out_valid/data/addr  result word (1-cycle pulse)
//   out_count            words emitted since start (wraps)
//   busy, layer_done     FSM not idle / drain finished pulse
//   err                  sticky: valid mismatch or unterminated word at drain end
module mm_mac_acc #(
  parameter int LANES     = mm_pkg::LANES,
  parameter int DW        = mm_pkg::DW,
  parameter int FRAC_BITS = mm_pkg::FRAC_BITS,
  parameter int AW        = mm_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     done,
  input  logic                     in_valid,
  input  logic [LANES*DW-1:0]      in_data,
  input  logic                     w_valid,
  input  logic [LANES*LANES*DW-1:0] w_data,
  input  logic                     in_last,
  input  logic [AW-1:0]            in_addr,
  output logic                     out_valid,
  output logic [LANES*DW-1:0]      out_data,
  output logic [AW-1:0]            out_addr,
  output logic [mm_pkg::CW-1:0]    out_count,
  output logic                     busy,
  output logic                     layer_done,
  output logic                     err
);
  import mm_pkg::*;

  state_t          state_reg;
  logic            drain_cnt_reg;
  logic            p1_valid_reg, p1_last_reg;
  logic [AW-1:0]   p1_addr_reg;
  logic            pending_reg;   // accumulator holds a word without its last chunk

  logic accept, mismatch, drain_end, s2_en, s2_out, acc_clr, leftover;

  // start pre-empts everything else in its cycle, including a chunk on the bus.
  assign accept    = (state_reg == ST_RUN) && in_valid && w_valid && !start;
  assign mismatch  = (state_reg == ST_RUN) && (in_valid ^ w_valid) && !start;
  assign drain_end = (state_reg == ST_DRAIN) && drain_cnt_reg && !start;
  assign s2_en     = p1_valid_reg && !start;
  assign s2_out    = s2_en && p1_last_reg;
  assign acc_clr   = start || drain_end;
  // Unterminated word state as it stands after this cycle's stage-2 update.
  assign leftover  = s2_en ? !p1_last_reg : pending_reg;
  assign busy      = (state_reg != ST_IDLE);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_row
      mm_mac_row #(.N(LANES), .W(DW), .FB(FRAC_BITS)) u_row (
        .clk     (clk),
        .rstn    (rstn),
        .load    (accept),
        .x       (in_data),
        .wrow    (w_data[gi*LANES*DW +: LANES*DW]),
        .s2_en   (s2_en),
        .s2_last (p1_last_reg),
        .acc_clr (acc_clr),
        .row_out (out_data[gi*DW +: DW])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= 1'b0;
      p1_valid_reg  <= 1'b0;
      p1_last_reg   <= 1'b0;
      p1_addr_reg   <= '0;
      pending_reg   <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_count     <= '0;
      layer_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      layer_done   <= 1'b0;
      out_valid    <= s2_out;
      p1_valid_reg <= accept;
      if (accept) begin
        p1_last_reg <= in_last;
        p1_addr_reg <= in_addr;
      end
      if (s2_out) begin
        out_addr  <= p1_addr_reg;
        out_count <= out_count + 1'b1;
      end
      if (acc_clr)    pending_reg <= 1'b0;
      else if (s2_en) pending_reg <= !p1_last_reg;

      if (start) begin
        state_reg     <= ST_RUN;
        drain_cnt_reg <= 1'b0;
        out_count     <= '0;
        err           <= 1'b0;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (mismatch) err <= 1'b1;
            if (done) begin
              state_reg     <= ST_DRAIN;
              drain_cnt_reg <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_reg) begin
              state_reg  <= ST_IDLE;
              layer_done <= 1'b1;
              if (leftover) err <= 1'b1;
            end else begin
              drain_cnt_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mm_mac_acc.sv
// Scoreboard bench for mm_mac_acc: two instances (FRAC_BITS 0 and 16) share
// stimulus; a behavioural model predicts each emitted word and a negedge
// monitor pops and compares whenever a DUT presents out_valid.
module tb_mm_mac_acc;
  import mm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn = 1'b0, start = 1'b0, done = 1'b0;
  logic         in_valid = 1'b0, w_valid = 1'b0, in_last = 1'b0;
  logic [10:0]  in_addr = '0;
  logic [511:0] in_data = '0;
  logic [8191:0] w_data = '0;

  logic         out_valid0, out_valid1, busy0, busy1, ld0, ld1, err0, err1;
  logic [511:0] out_data0, out_data1;
  logic [10:0]  out_addr0, out_addr1;
  logic [15:0]  out_count0, out_count1;

  mm_mac_acc dut0 (
    .clk(clk), .rstn(rstn), .start(start), .done(done),
    .in_valid(in_valid), .in_data(in_data), .w_valid(w_valid), .w_data(w_data),
    .in_last(in_last), .in_addr(in_addr),
    .out_valid(out_valid0), .out_data(out_data0), .out_addr(out_addr0),
    .out_count(out_count0), .busy(busy0), .layer_done(ld0), .err(err0));

  mm_mac_acc #(.FRAC_BITS(16)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .done(done),
    .in_valid(in_valid), .in_data(in_data), .w_valid(w_valid), .w_data(w_data),
    .in_last(in_last), .in_addr(in_addr),
    .out_valid(out_valid1), .out_data(out_data1), .out_addr(out_addr1),
    .out_count(out_count1), .busy(busy1), .layer_done(ld1), .err(err1));

  typedef struct {
    logic [511:0] d;
    logic [10:0]  a;
    logic [15:0]  c;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   tests = 0, errors = 0;
  int   pops0 = 0, pops1 = 0, run0 = 0, max_run0 = 0;
  logic [511:0] last_d0 = '0, last_d1 = '0;
  logic [10:0]  last_a0 = '0;
  logic [15:0]  last_c0 = '0;

  // Behavioural model state
  logic [31:0] macc0 [16];
  logic [31:0] macc1 [16];
  bit          m_pending, m_err, m_ld;
  int          m_state, m_dcnt;   // 0 idle, 1 run, 2 drain
  logic [15:0] m_count;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mprod(input logic [31:0] w, input logic [31:0] x, input int fb);
    longint p;
    p = longint'($signed(w)) * longint'($signed(x));
    p = p >>> fb;
    return p[31:0];
  endfunction

  task automatic clear_acc();
    for (int r = 0; r < 16; r++) begin
      macc0[r] = '0;
      macc1[r] = '0;
    end
    m_pending = 0;
  endtask

  task automatic model_reset();
    clear_acc();
    q0.delete();
    q1.delete();
    m_err = 0; m_ld = 0; m_state = 0; m_dcnt = 0; m_count = '0;
  endtask

  // One accepted chunk: out[r] += sum_c trunc((W[r][c]*x[c]) >>> fb)
  task automatic model_chunk(input bit lst, input logic [10:0] ad);
    exp_t x0, x1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        macc0[r] = macc0[r] + mprod(w_data[(r*16+c)*32 +: 32], lane_get(in_data, c), 0);
        macc1[r] = macc1[r] + mprod(w_data[(r*16+c)*32 +: 32], lane_get(in_data, c), 16);
      end
    if (lst) begin
      m_count = m_count + 16'd1;
      for (int r = 0; r < 16; r++) begin
        x0.d[r*32 +: 32] = macc0[r];
        x1.d[r*32 +: 32] = macc1[r];
      end
      x0.a = ad; x0.c = m_count;
      x1.a = ad; x1.c = m_count;
      q0.push_back(x0);
      q1.push_back(x1);
      clear_acc();
    end else begin
      m_pending = 1;
    end
  endtask

  // Drive one cycle (called at negedge), update the model at the sampling
  // edge, then check the control outputs at the following negedge.
  task automatic cycle(input bit iv, input bit wv, input bit lst, input logic [10:0] ad,
                       input bit st, input bit dn);
    in_valid = iv; w_valid = wv; in_last = lst; in_addr = ad; start = st; done = dn;
    @(posedge clk);
    m_ld = 0;
    if (st) begin
      clear_acc();
      q0.delete();
      q1.delete();
      m_count = '0; m_err = 0; m_state = 1; m_dcnt = 0;
    end else if (m_state == 1) begin
      if (iv && wv) model_chunk(lst, ad);
      else if (iv ^ wv) m_err = 1;
      if (dn) begin m_state = 2; m_dcnt = 0; end
    end else if (m_state == 2) begin
      m_dcnt++;
      if (m_dcnt == 2) begin
        m_state = 0;
        m_ld = 1;
        if (m_pending) begin m_err = 1; clear_acc(); end
      end
    end
    @(negedge clk);
    chk("busy0", 64'(busy0), 64'(m_state != 0));
    chk("busy1", 64'(busy1), 64'(m_state != 0));
    chk("layer_done0", 64'(ld0), 64'(m_ld));
    chk("layer_done1", 64'(ld1), 64'(m_ld));
    chk("err0", 64'(err0), 64'(m_err));
    chk("err1", 64'(err1), 64'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++)  in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 256; i++) w_data[i*32 +: 32] = $urandom;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid0) begin
      pops0++; run0++;
      if (run0 > max_run0) max_run0 = run0;
      tests++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL out0_unexpected: got out_valid=1 addr=%0d required no output", out_addr0);
      end else begin
        e0 = q0.pop_front();
        if (out_data0 !== e0.d || out_addr0 !== e0.a || out_count0 !== e0.c) begin
          errors++;
          $display("FAIL out0_word: got addr=%0d cnt=%0d data=%h required addr=%0d cnt=%0d data=%h",
                   out_addr0, out_count0, out_data0, e0.a, e0.c, e0.d);
        end
      end
      last_d0 = out_data0; last_a0 = out_addr0; last_c0 = out_count0;
    end else begin
      run0 = 0;
    end
    if (out_valid1) begin
      pops1++;
      tests++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected: got out_valid=1 addr=%0d required no output", out_addr1);
      end else begin
        e1 = q1.pop_front();
        if (out_data1 !== e1.d || out_addr1 !== e1.a || out_count1 !== e1.c) begin
          errors++;
          $display("FAIL out1_word: got addr=%0d cnt=%0d data=%h required addr=%0d cnt=%0d data=%h",
                   out_addr1, out_count1, out_data1, e1.a, e1.c, e1.d);
        end
      end
      last_d1 = out_data1;
    end
  end

  initial begin
    int p0;
    logic [511:0] ref_vec;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid0 | out_valid1), 64'd0);
    chk("rst_out_data", 64'(|{out_data0, out_data1}), 64'd0);
    chk("rst_out_addr", 64'({out_addr0, out_addr1}), 64'd0);
    chk("rst_out_count", 64'({out_count0, out_count1}), 64'd0);
    chk("rst_busy_ld_err", 64'({busy0, ld0, err0, busy1, ld1, err1}), 64'd0);
    rstn = 1'b1;
    idle(1);

    // 1: Ci=1, identity weights, in=[1..16], addr 5
    cycle(0, 0, 0, '0, 1, 0);
    w_data = '0;
    for (int i = 0; i < 16; i++) begin
      in_data[i*32 +: 32] = 32'(i + 1);
      w_data[(i*16+i)*32 +: 32] = 32'd1;
    end
    cycle(1, 1, 1, 11'd5, 0, 0);
    idle(2);
    #1;
    for (int i = 0; i < 16; i++) ref_vec[i*32 +: 32] = 32'(i + 1);
    chk("t1_identity_data_hi", last_d0[511:448], ref_vec[511:448]);
    chk("t1_identity_data_lo", last_d0[63:0], ref_vec[63:0]);
    chk("t1_addr", 64'(last_a0), 64'd5);
    chk("t1_count", 64'(last_c0), 64'd1);

    // 2: Ci=3, all-ones weights, in all 2 -> 96 per lane, one word only
    p0 = pops0;
    for (int i = 0; i < 256; i++) w_data[i*32 +: 32] = 32'd1;
    for (int i = 0; i < 16; i++)  in_data[i*32 +: 32] = 32'd2;
    cycle(1, 1, 0, 11'd9, 0, 0);
    cycle(1, 1, 0, 11'd9, 0, 0);
    cycle(1, 1, 1, 11'd9, 0, 0);
    idle(3);
    #1;
    chk("t2_one_output", 64'(pops0 - p0), 64'd1);
    chk("t2_lane0", 64'(last_d0[31:0]), 64'd96);
    chk("t2_lane15", 64'(last_d0[511:480]), 64'd96);

    // 3: back-to-back Ci=1 words at addr 0..7, then done; chunk in IDLE ignored
    max_run0 = 0;
    for (int a = 0; a < 8; a++) begin
      rand_data();
      cycle(1, 1, 1, 11'(a), 0, 0);
    end
    cycle(0, 0, 0, '0, 0, 1);
    idle(3);
    rand_data();
    cycle(1, 1, 1, 11'd3, 0, 0);
    idle(3);
    chk("t3_no_bubble", 64'(max_run0), 64'd8);

    // 4: valid mismatch sets err, chunk dropped
    cycle(0, 0, 0, '0, 1, 0);
    rand_data(); cycle(1, 1, 0, 11'd20, 0, 0);
    rand_data(); cycle(1, 0, 0, 11'd20, 0, 0);
    rand_data(); cycle(0, 1, 1, 11'd20, 0, 0);
    rand_data(); cycle(1, 1, 1, 11'd20, 0, 0);
    idle(3);

    // 5: wrap-around and fixed-point scaling
    w_data = '0; in_data = '0;
    w_data[31:0]  = 32'h7FFFFFFF; w_data[63:32] = 32'd1;
    in_data[31:0] = 32'd1;        in_data[63:32] = 32'd1;
    cycle(1, 1, 1, 11'd30, 0, 0);
    idle(3);
    #1;
    chk("t5_wrap", 64'(last_d0[31:0]), 64'h80000000);
    w_data = '0; in_data = '0;
    w_data[31:0] = 32'h00020000; in_data[31:0] = 32'h00030000;
    cycle(1, 1, 1, 11'd31, 0, 0);
    idle(3);
    #1;
    chk("t5_fixed_point", 64'(last_d1[31:0]), 64'h00060000);

    // 6: start right after a closing chunk suppresses it; reset mid-RUN
    p0 = pops0;
    rand_data();
    cycle(1, 1, 1, 11'd40, 0, 0);
    cycle(0, 0, 0, '0, 1, 0);
    idle(3);
    chk("t6_flushed", 64'(pops0 - p0), 64'd0);
    rand_data();
    cycle(1, 1, 0, 11'd41, 0, 0);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_outputs", 64'(|{out_valid0, out_data0, out_addr0, out_count0, busy0, ld0, err0}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Randomized layers
    for (int L = 0; L < 20; L++) begin
      int  nw, ci;
      bit  dsent, lst, dn;
      logic [10:0] ad;
      cycle(0, 0, 0, '0, 1, 0);
      nw = $urandom_range(1, 4);
      dsent = 0;
      for (int w = 0; w < nw; w++) begin
        ci = $urandom_range(1, 3);
        ad = 11'($urandom);
        for (int k = 0; k < ci; k++) begin
          if ($urandom_range(0, 7) == 0) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            rand_data();
            cycle(b, !b, 1'($urandom_range(0, 1)), ad, 0, 0);
          end
          rand_data();
          lst = (k == ci - 1) && !(w == nw - 1 && $urandom_range(0, 4) == 0);
          dn  = (w == nw - 1) && (k == ci - 1) && ($urandom_range(0, 1) == 1);
          cycle(1, 1, lst, ad, 0, dn);
          if (dn) dsent = 1;
          if (!dn && $urandom_range(0, 3) == 0) idle(1);
        end
      end
      if (!dsent) cycle(0, 0, 0, '0, 0, 1);
      idle(3);
    end

    idle(4);
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
